// File: rtl/sum_arb_pkg.sv
// Shared encodings and constants for the round-robin front end of a shared FP adder.
package sum_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam int          TIMEOUT_DEF = 64;
  localparam logic [31:0] ONE         = 32'h3F80_0000;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request bit searching upward from ptr+1, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    any   = |req;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        grant = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sum_arbiter.sv
// Shares one externally attached sum_fsm adder among N_REQ requesters, with a
// WAIT-state watchdog that completes a hung transaction with err=1.
module sum_arbiter
  import sum_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [32*N_REQ-1:0] op_a,
  input  logic [32*N_REQ-1:0] op_b,
  output logic [N_REQ-1:0]    done,
  output logic [31:0]         res,
  output logic                err,
  output logic                su_ri,
  output logic [31:0]         su_a,
  output logic [31:0]         su_b,
  input  logic [31:0]         su_res,
  input  logic                su_ro,
  output logic [1:0]          state_out
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q, grant_q;
  logic [TW-1:0]      timer_q;
  logic [N_REQ-1:0]   done_q;
  logic [31:0]        res_q, su_a_q, su_b_q;
  logic               err_q, su_ri_q;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      timer_q <= '0;
      done_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      su_ri_q <= 1'b0;
      su_a_q  <= '0;
      su_b_q  <= '0;
    end else begin
      // Pulses are high only for the single cycle spent in ISSUE / DONE.
      su_ri_q <= 1'b0;
      done_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            su_a_q  <= op_a[int'(pick_idx)*32 +: 32];
            su_b_q  <= op_b[int'(pick_idx)*32 +: 32];
            su_ri_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A ready arriving on the timeout cycle still delivers its result.
          if (su_ro) begin
            res_q           <= su_res;
            err_q           <= 1'b0;
            done_q[grant_q] <= 1'b1;
            state_q         <= S_DONE;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            res_q           <= '0;
            err_q           <= 1'b1;
            done_q[grant_q] <= 1'b1;
            state_q         <= S_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_DONE: begin
          ptr_q   <= grant_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign res       = res_q;
  assign err       = err_q;
  assign su_ri     = su_ri_q;
  assign su_a      = su_a_q;
  assign su_b      = su_b_q;
  assign state_out = state_q;

endmodule
